// File: rtl/axi_read_arbiter.sv
// Two-master AXI4 read-channel arbiter: M0 = instruction fetch, M1 = LSU loads.
// One read transaction is outstanding at a time. The grant is held from AR acceptance until the last R beat.
module axi_read_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              i_clock,
  input  logic              i_reset_n,

  input  logic [ADDR_W-1:0] i_m0_araddr,
  input  logic [3:0]        i_m0_arid,
  input  logic [7:0]        i_m0_arlen,
  input  logic [2:0]        i_m0_arsize,
  input  logic [1:0]        i_m0_arburst,
  input  logic              i_m0_arvalid,
  output logic              o_m0_arready,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic [1:0]        o_m0_rresp,
  output logic [3:0]        o_m0_rid,
  output logic              o_m0_rvalid,
  output logic              o_m0_rlast,
  input  logic              i_m0_rready,

  input  logic [ADDR_W-1:0] i_m1_araddr,
  input  logic [3:0]        i_m1_arid,
  input  logic [7:0]        i_m1_arlen,
  input  logic [2:0]        i_m1_arsize,
  input  logic [1:0]        i_m1_arburst,
  input  logic              i_m1_arvalid,
  output logic              o_m1_arready,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [1:0]        o_m1_rresp,
  output logic [3:0]        o_m1_rid,
  output logic              o_m1_rvalid,
  output logic              o_m1_rlast,
  input  logic              i_m1_rready,

  output logic [ADDR_W-1:0] o_axi_araddr,
  output logic [3:0]        o_axi_arid,
  output logic [7:0]        o_axi_arlen,
  output logic [2:0]        o_axi_arsize,
  output logic [1:0]        o_axi_arburst,
  output logic              o_axi_arvalid,
  input  logic              i_axi_arready,

  input  logic [DATA_W-1:0] i_axi_rdata,
  input  logic [1:0]        i_axi_rresp,
  input  logic [3:0]        i_axi_rid,
  input  logic              i_axi_rlast,
  input  logic              i_axi_rvalid,
  output logic              o_axi_rready,

  output logic              o_busy,
  output logic              o_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt;
  logic   last_grant, last_grant_nxt;
  logic   r_beat_last;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  assign r_beat_last = i_axi_rvalid && o_axi_rready && i_axi_rlast;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (i_m0_arvalid || i_m1_arvalid) begin
          state_nxt = ADDR;
          if (i_m0_arvalid && i_m1_arvalid) grant_nxt = FIXED_PRIO ? 1'b1 : ~last_grant;
          else                              grant_nxt = i_m1_arvalid;
        end
      end
      ADDR: begin
        if (i_axi_arready) begin
          last_grant_nxt = grant;
          state_nxt      = DATA;
        end
      end
      DATA: begin
        if (r_beat_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Downstream AR payload follows the held grant; it only matters while arvalid is high.
  always_comb begin
    o_axi_araddr  = grant ? i_m1_araddr  : i_m0_araddr;
    o_axi_arid    = grant ? i_m1_arid    : i_m0_arid;
    o_axi_arlen   = grant ? i_m1_arlen   : i_m0_arlen;
    o_axi_arsize  = grant ? i_m1_arsize  : i_m0_arsize;
    o_axi_arburst = grant ? i_m1_arburst : i_m0_arburst;
  end

  assign o_axi_arvalid = (state == ADDR);
  assign o_m0_arready  = (state == ADDR) && !grant && i_axi_arready;
  assign o_m1_arready  = (state == ADDR) &&  grant && i_axi_arready;

  // R beats outside DATA are protocol errors: never accepted, never forwarded.
  assign o_axi_rready = (state == DATA) && (grant ? i_m1_rready : i_m0_rready);
  assign o_m0_rvalid  = (state == DATA) && !grant && i_axi_rvalid;
  assign o_m1_rvalid  = (state == DATA) &&  grant && i_axi_rvalid;

  assign o_m0_rdata = i_axi_rdata;
  assign o_m0_rresp = i_axi_rresp;
  assign o_m0_rid   = i_axi_rid;
  assign o_m0_rlast = i_axi_rlast;
  assign o_m1_rdata = i_axi_rdata;
  assign o_m1_rresp = i_axi_rresp;
  assign o_m1_rid   = i_axi_rid;
  assign o_m1_rlast = i_axi_rlast;

  assign o_busy  = (state != IDLE);
  assign o_grant = grant;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a round-robin instance (d_*) and a fixed-priority
// instance (f_*) share one set of master and downstream stimulus.
module tb_axi_read_arbiter;

  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A1 = 32'h0000_4000;

  logic        i_clock = 1'b0;
  logic        i_reset_n;

  logic [31:0] m0_araddr, m1_araddr;
  logic [3:0]  m0_arid, m1_arid;
  logic [7:0]  m0_arlen, m1_arlen;
  logic [2:0]  m0_arsize, m1_arsize;
  logic [1:0]  m0_arburst, m1_arburst;
  logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;
  logic        axi_arready, axi_rlast, axi_rvalid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic [3:0]  axi_rid;

  logic        d_m0_arready, d_m0_rvalid, d_m0_rlast, d_m1_arready, d_m1_rvalid, d_m1_rlast;
  logic [31:0] d_m0_rdata, d_m1_rdata, d_axi_araddr;
  logic [1:0]  d_m0_rresp, d_m1_rresp, d_axi_arburst;
  logic [3:0]  d_m0_rid, d_m1_rid, d_axi_arid;
  logic [7:0]  d_axi_arlen;
  logic [2:0]  d_axi_arsize;
  logic        d_axi_arvalid, d_axi_rready, d_busy, d_grant;

  logic        f_m0_arready, f_m0_rvalid, f_m0_rlast, f_m1_arready, f_m1_rvalid, f_m1_rlast;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_axi_araddr;
  logic [1:0]  f_m0_rresp, f_m1_rresp, f_axi_arburst;
  logic [3:0]  f_m0_rid, f_m1_rid, f_axi_arid;
  logic [7:0]  f_axi_arlen;
  logic [2:0]  f_axi_arsize;
  logic        f_axi_arvalid, f_axi_rready, f_busy, f_grant;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clock = ~i_clock;

  axi_read_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b0)) dut_rr (
    .i_clock(i_clock), .i_reset_n(i_reset_n),
    .i_m0_araddr(m0_araddr), .i_m0_arid(m0_arid), .i_m0_arlen(m0_arlen), .i_m0_arsize(m0_arsize),
    .i_m0_arburst(m0_arburst), .i_m0_arvalid(m0_arvalid), .o_m0_arready(d_m0_arready),
    .o_m0_rdata(d_m0_rdata), .o_m0_rresp(d_m0_rresp), .o_m0_rid(d_m0_rid), .o_m0_rvalid(d_m0_rvalid),
    .o_m0_rlast(d_m0_rlast), .i_m0_rready(m0_rready),
    .i_m1_araddr(m1_araddr), .i_m1_arid(m1_arid), .i_m1_arlen(m1_arlen), .i_m1_arsize(m1_arsize),
    .i_m1_arburst(m1_arburst), .i_m1_arvalid(m1_arvalid), .o_m1_arready(d_m1_arready),
    .o_m1_rdata(d_m1_rdata), .o_m1_rresp(d_m1_rresp), .o_m1_rid(d_m1_rid), .o_m1_rvalid(d_m1_rvalid),
    .o_m1_rlast(d_m1_rlast), .i_m1_rready(m1_rready),
    .o_axi_araddr(d_axi_araddr), .o_axi_arid(d_axi_arid), .o_axi_arlen(d_axi_arlen),
    .o_axi_arsize(d_axi_arsize), .o_axi_arburst(d_axi_arburst), .o_axi_arvalid(d_axi_arvalid),
    .i_axi_arready(axi_arready), .i_axi_rdata(axi_rdata), .i_axi_rresp(axi_rresp), .i_axi_rid(axi_rid),
    .i_axi_rlast(axi_rlast), .i_axi_rvalid(axi_rvalid), .o_axi_rready(d_axi_rready),
    .o_busy(d_busy), .o_grant(d_grant)
  );

  axi_read_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b1)) dut_fp (
    .i_clock(i_clock), .i_reset_n(i_reset_n),
    .i_m0_araddr(m0_araddr), .i_m0_arid(m0_arid), .i_m0_arlen(m0_arlen), .i_m0_arsize(m0_arsize),
    .i_m0_arburst(m0_arburst), .i_m0_arvalid(m0_arvalid), .o_m0_arready(f_m0_arready),
    .o_m0_rdata(f_m0_rdata), .o_m0_rresp(f_m0_rresp), .o_m0_rid(f_m0_rid), .o_m0_rvalid(f_m0_rvalid),
    .o_m0_rlast(f_m0_rlast), .i_m0_rready(m0_rready),
    .i_m1_araddr(m1_araddr), .i_m1_arid(m1_arid), .i_m1_arlen(m1_arlen), .i_m1_arsize(m1_arsize),
    .i_m1_arburst(m1_arburst), .i_m1_arvalid(m1_arvalid), .o_m1_arready(f_m1_arready),
    .o_m1_rdata(f_m1_rdata), .o_m1_rresp(f_m1_rresp), .o_m1_rid(f_m1_rid), .o_m1_rvalid(f_m1_rvalid),
    .o_m1_rlast(f_m1_rlast), .i_m1_rready(m1_rready),
    .o_axi_araddr(f_axi_araddr), .o_axi_arid(f_axi_arid), .o_axi_arlen(f_axi_arlen),
    .o_axi_arsize(f_axi_arsize), .o_axi_arburst(f_axi_arburst), .o_axi_arvalid(f_axi_arvalid),
    .i_axi_arready(axi_arready), .i_axi_rdata(axi_rdata), .i_axi_rresp(axi_rresp), .i_axi_rid(axi_rid),
    .i_axi_rlast(axi_rlast), .i_axi_rvalid(axi_rvalid), .o_axi_rready(f_axi_rready),
    .o_busy(f_busy), .o_grant(f_grant)
  );

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge i_clock);
    #1;
  endtask

  task automatic clear_inputs();
    m0_araddr = A0; m0_arid = 4'h1; m0_arlen = 8'd0; m0_arsize = 3'd2; m0_arburst = 2'd1;
    m1_araddr = A1; m1_arid = 4'h2; m1_arlen = 8'd0; m1_arsize = 3'd2; m1_arburst = 2'd1;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
    axi_rdata = '0; axi_rresp = 2'b00; axi_rid = 4'h0;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    clear_inputs();
    cycle();
    cycle();
    i_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if ({d_busy, d_axi_arvalid, d_axi_rready} !== 3'b000) begin
      miscompares++; $display("FAIL reset_idle busy/arvalid/rready got=%b exp=000", {d_busy, d_axi_arvalid, d_axi_rready}); end
    vectors++; if (d_grant !== 1'b0) begin miscompares++; $display("FAIL reset_grant got=%b exp=0", d_grant); end
    m0_arvalid = 1'b1;
    cycle();
    axi_arready = 1'b1;
    cycle();
    m0_arvalid = 1'b0; axi_arready = 1'b0;
    axi_rvalid = 1'b1; axi_rlast = 1'b0; m0_rready = 1'b1;
    #1;
    vectors++; if ({d_busy, d_axi_rready} !== 2'b11) begin
      miscompares++; $display("FAIL reset_pre_data busy/rready got=%b exp=11", {d_busy, d_axi_rready}); end
    axi_arready = 1'b1;
    i_reset_n = 1'b0;
    #1;
    vectors++; if ({d_busy, d_axi_arvalid, d_axi_rready} !== 3'b000) begin
      miscompares++; $display("FAIL reset_mid_data busy/arvalid/rready got=%b exp=000", {d_busy, d_axi_arvalid, d_axi_rready}); end
    vectors++; if ({d_m0_arready, d_m1_arready, d_m0_rvalid, d_m1_rvalid} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_mid_data arready/rvalid got=%b exp=0000", {d_m0_arready, d_m1_arready, d_m0_rvalid, d_m1_rvalid}); end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000; m0_arid = 4'h5; m0_arlen = 8'd0;
    #1;
    vectors++; if (d_axi_arvalid !== 1'b0) begin miscompares++; $display("FAIL single_no_comb_arvalid got=%b exp=0", d_axi_arvalid); end
    cycle();
    vectors++; if (d_axi_arvalid !== 1'b1) begin miscompares++; $display("FAIL single_arvalid got=%b exp=1", d_axi_arvalid); end
    vectors++; if (d_axi_araddr !== 32'h8000_0000) begin miscompares++; $display("FAIL single_araddr got=%h exp=80000000", d_axi_araddr); end
    vectors++; if ({d_axi_arid, d_axi_arlen, d_axi_arsize, d_axi_arburst} !== {4'h5, 8'd0, 3'd2, 2'd1}) begin
      miscompares++; $display("FAIL single_ar_payload got=%h exp=%h", {d_axi_arid, d_axi_arlen, d_axi_arsize, d_axi_arburst}, {4'h5, 8'd0, 3'd2, 2'd1}); end
    vectors++; if ({d_busy, d_grant, d_m0_arready} !== 3'b100) begin
      miscompares++; $display("FAIL single_addr_wait busy/grant/arready got=%b exp=100", {d_busy, d_grant, d_m0_arready}); end
    axi_arready = 1'b1;
    #1;
    vectors++; if ({d_m0_arready, d_m1_arready} !== 2'b10) begin
      miscompares++; $display("FAIL single_arready got=%b exp=10", {d_m0_arready, d_m1_arready}); end
    cycle();
    m0_arvalid = 1'b0; axi_arready = 1'b0;
    axi_rvalid = 1'b1; axi_rdata = 32'hDEAD_BEEF; axi_rlast = 1'b1; axi_rresp = 2'b10; axi_rid = 4'h5;
    m0_rready = 1'b1;
    #1;
    vectors++; if ({d_m0_rvalid, d_m1_rvalid, d_axi_rready} !== 3'b101) begin
      miscompares++; $display("FAIL single_rvalid m0/m1/rready got=%b exp=101", {d_m0_rvalid, d_m1_rvalid, d_axi_rready}); end
    vectors++; if (d_m0_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_rdata got=%h exp=deadbeef", d_m0_rdata); end
    vectors++; if ({d_m0_rresp, d_m0_rid, d_m0_rlast} !== {2'b10, 4'h5, 1'b1}) begin
      miscompares++; $display("FAIL single_r_payload got=%h exp=%h", {d_m0_rresp, d_m0_rid, d_m0_rlast}, {2'b10, 4'h5, 1'b1}); end
    cycle();
    axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
    vectors++; if (d_busy !== 1'b0) begin miscompares++; $display("FAIL single_done_busy got=%b exp=0", d_busy); end
  endtask

  task automatic test_rr_tie();
    int n = 0;
    do_reset();
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
    axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rlast = 1'b1;
    for (int c = 0; c < 20 && n < 4; c++) begin
      cycle();
      if (d_axi_arvalid) begin
        vectors++; if (d_grant !== n[0]) begin miscompares++; $display("FAIL rr_order[%0d] got=M%0d exp=M%0d", n, d_grant, n[0]); end
        vectors++; if (d_axi_araddr !== (n[0] ? A1 : A0)) begin
          miscompares++; $display("FAIL rr_araddr[%0d] got=%h exp=%h", n, d_axi_araddr, n[0] ? A1 : A0); end
        n++;
      end
    end
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL rr_count got=%0d exp=4", n); end
  endtask

  task automatic test_fixed_prio();
    int n;
    do_reset();
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
    axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rlast = 1'b1; axi_rdata = 32'h1234_5678; axi_rid = 4'h2;
    for (int phase = 0; phase < 2; phase++) begin
      n = 0;
      if (phase == 1) m1_arvalid = 1'b0;
      for (int c = 0; c < 12 - 3 * phase; c++) begin
        cycle();
        if (f_axi_arvalid) begin
          vectors++; if (f_grant !== ~phase[0]) begin
            miscompares++; $display("FAIL fp_grant phase%0d got=M%0d exp=M%0d", phase, f_grant, ~phase[0]); end
          vectors++; if ({f_m1_arready, f_m0_arready} !== {~phase[0], phase[0]}) begin
            miscompares++; $display("FAIL fp_arready phase%0d got=%b exp=%b", phase, {f_m1_arready, f_m0_arready}, {~phase[0], phase[0]}); end
          vectors++; if (f_axi_araddr !== (phase == 0 ? A1 : A0)) begin
            miscompares++; $display("FAIL fp_araddr phase%0d got=%h", phase, f_axi_araddr); end
          vectors++; if ({f_axi_arid, f_axi_arlen, f_axi_arsize, f_axi_arburst} !== (phase == 0 ? {4'h2, 8'd0, 3'd2, 2'd1} : {4'h1, 8'd0, 3'd2, 2'd1})) begin
            miscompares++; $display("FAIL fp_ar_payload phase%0d got=%h", phase, {f_axi_arid, f_axi_arlen, f_axi_arsize, f_axi_arburst}); end
          n++;
        end else if (f_busy) begin
          vectors++; if ({f_m1_rvalid, f_m0_rvalid, f_axi_rready} !== {~phase[0], phase[0], 1'b1}) begin
            miscompares++; $display("FAIL fp_rvalid phase%0d got=%b exp=%b", phase, {f_m1_rvalid, f_m0_rvalid, f_axi_rready}, {~phase[0], phase[0], 1'b1}); end
          vectors++; if ({f_m0_rdata, f_m0_rresp, f_m0_rid, f_m0_rlast, f_m1_rdata, f_m1_rresp, f_m1_rid, f_m1_rlast}
                         !== {32'h1234_5678, 2'b00, 4'h2, 1'b1, 32'h1234_5678, 2'b00, 4'h2, 1'b1}) begin
            miscompares++; $display("FAIL fp_r_payload phase%0d got=%h", phase, {f_m0_rdata, f_m1_rdata}); end
        end else begin
          vectors++; if ({f_axi_rready, f_m0_rvalid, f_m1_rvalid} !== 3'b000) begin
            miscompares++; $display("FAIL fp_idle_rbeat got=%b exp=000", {f_axi_rready, f_m0_rvalid, f_m1_rvalid}); end
        end
      end
      vectors++; if (n !== 4 - phase) begin miscompares++; $display("FAIL fp_count phase%0d got=%0d exp=%0d", phase, n, 4 - phase); end
    end
  endtask

  task automatic test_burst_hold();
    do_reset();
    m0_arvalid = 1'b1; m0_arlen = 8'd3; m1_arvalid = 1'b1;
    cycle();
    vectors++; if ({d_axi_arvalid, d_grant, d_axi_arlen} !== {1'b1, 1'b0, 8'd3}) begin
      miscompares++; $display("FAIL burst_addr arvalid/grant/arlen got=%h exp=%h", {d_axi_arvalid, d_grant, d_axi_arlen}, {1'b1, 1'b0, 8'd3}); end
    axi_arready = 1'b1;
    #1;
    vectors++; if ({d_m0_arready, d_m1_arready} !== 2'b10) begin
      miscompares++; $display("FAIL burst_arready got=%b exp=10", {d_m0_arready, d_m1_arready}); end
    cycle();
    m0_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi_rvalid = 1'b1; axi_rdata = 32'hA0 + i; axi_rlast = (i == 3); axi_rresp = (i == 1) ? 2'b10 : 2'b00;
      m0_rready = 1'b1;
      #1;
      vectors++; if ({d_m1_arready, d_m0_rvalid, d_m1_rvalid, d_busy} !== 4'b0101) begin
        miscompares++; $display("FAIL burst_beat%0d m1_arready/m0_rvalid/m1_rvalid/busy got=%b exp=0101", i, {d_m1_arready, d_m0_rvalid, d_m1_rvalid, d_busy}); end
      vectors++; if (d_m0_rdata !== 32'hA0 + i) begin miscompares++; $display("FAIL burst_rdata%0d got=%h exp=%h", i, d_m0_rdata, 32'hA0 + i); end
      vectors++; if ({d_m1_rdata, d_m1_rresp, d_m1_rlast} !== {32'hA0 + i, (i == 1) ? 2'b10 : 2'b00, i == 3}) begin
        miscompares++; $display("FAIL burst_m1_copy%0d got=%h", i, {d_m1_rdata, d_m1_rresp, d_m1_rlast}); end
      cycle();
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
    #1;
    vectors++; if ({d_busy, d_m1_arready, d_axi_arvalid} !== 3'b000) begin
      miscompares++; $display("FAIL burst_gap busy/m1_arready/arvalid got=%b exp=000", {d_busy, d_m1_arready, d_axi_arvalid}); end
    cycle();
    vectors++; if ({d_grant, d_m1_arready, d_m0_arready} !== 3'b110) begin
      miscompares++; $display("FAIL burst_m1_grant grant/m1_arready/m0_arready got=%b exp=110", {d_grant, d_m1_arready, d_m0_arready}); end
    vectors++; if (d_axi_araddr !== A1) begin miscompares++; $display("FAIL burst_m1_araddr got=%h exp=%h", d_axi_araddr, A1); end
    cycle();
    m1_arvalid = 1'b0; axi_arready = 1'b0;
    axi_rvalid = 1'b1; axi_rlast = 1'b1; axi_rid = 4'h2; m1_rready = 1'b1;
    #1;
    vectors++; if ({d_m1_rvalid, d_m0_rvalid, d_m1_rid} !== {1'b1, 1'b0, 4'h2}) begin
      miscompares++; $display("FAIL burst_m1_data got=%b exp=1_0_0010", {d_m1_rvalid, d_m0_rvalid, d_m1_rid}); end
    cycle();
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
  endtask

  task automatic test_backpressure();
    int got, gap, d;
    bit hs;
    for (int rep = 0; rep < 3; rep++) begin
      do_reset();
      m1_arvalid = 1'b1; m1_arlen = 8'd3;
      cycle();
      d = $urandom_range(0, 5);
      for (int k = 0; k < d; k++) begin
        vectors++; if ({d_axi_arvalid, d_m1_arready} !== 2'b10) begin
          miscompares++; $display("FAIL bp_ar_wait arvalid/arready got=%b exp=10", {d_axi_arvalid, d_m1_arready}); end
        cycle();
      end
      axi_arready = 1'b1;
      cycle();
      axi_arready = 1'b0; m1_arvalid = 1'b0;
      got = 0; gap = $urandom_range(0, 5);
      for (int c = 0; c < 200 && got < 4; c++) begin
        if (!axi_rvalid) begin
          if (gap == 0) begin
            axi_rvalid = 1'b1; axi_rdata = 32'h100 + got; axi_rlast = (got == 3);
          end else gap--;
        end
        m1_rready = ~m1_rready;
        #1;
        vectors++; if (d_axi_rready !== m1_rready) begin
          miscompares++; $display("FAIL bp_rready_mirror got=%b exp=%b", d_axi_rready, m1_rready); end
        vectors++; if ({d_m1_rvalid, d_m0_rvalid} !== {axi_rvalid, 1'b0}) begin
          miscompares++; $display("FAIL bp_rvalid got=%b exp=%b", {d_m1_rvalid, d_m0_rvalid}, {axi_rvalid, 1'b0}); end
        hs = axi_rvalid && m1_rready;
        if (hs) begin
          vectors++; if (d_m1_rdata !== 32'h100 + got) begin
            miscompares++; $display("FAIL bp_beat%0d got=%h exp=%h", got, d_m1_rdata, 32'h100 + got); end
          got++;
        end
        cycle();
        if (hs) begin
          axi_rvalid = 1'b0; axi_rlast = 1'b0; gap = $urandom_range(0, 5);
        end
      end
      vectors++; if (got !== 4) begin miscompares++; $display("FAIL bp_beat_count got=%0d exp=4", got); end
      vectors++; if (d_busy !== 1'b0) begin miscompares++; $display("FAIL bp_done_busy got=%b exp=0", d_busy); end
    end
  endtask

  initial begin
    i_reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_rr_tie();
    test_fixed_prio();
    test_burst_hold();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
